// File: rtl/rhs_frame_packer.sv
// rtl/rhs_frame_packer.sv - frames per-channel RHS2116 slot results into a 32-bit word stream
// Slot FIFO on the push side; a serializer emits header, frame count, sample words and trailer.
module rhs_frame_packer #(
  parameter int          NUM_CH     = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MAGIC      = 32'hA55A_C3C3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         enable,
  input  logic         in_valid,
  input  logic [7:0]   in_channel,
  input  logic [255:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         frame_done,
  output logic         overflow
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [8:0] LP_NCH   = 9'(NUM_CH);
  localparam logic [7:0] LP_LAST  = 8'(NUM_CH - 1);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CNT, S_DATA, S_TRL} state_t;

  // entry tag layout: {sof, eof, ovf, seq}
  logic [255:0]  r_mem_data [FIFO_DEPTH];
  logic [3:0]    r_mem_tag  [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  logic        r_synced, r_ovf_pend, r_seq_pend, r_enable_d, r_overflow;
  logic [7:0]  r_expected;

  state_t      r_state, w_state_n;
  logic [2:0]  r_k, w_k_n;
  logic        r_out_valid, w_out_valid_n;
  logic [31:0] r_out_data, w_out_data_n;
  logic [31:0] r_frame_cnt, w_frame_cnt_n;
  logic        r_frame_open, w_frame_open_n;
  logic [7:0]  r_rx_cnt, w_rx_cnt_n;
  logic        r_frame_done, w_frame_done_n;
  logic        w_pop;

  logic w_acc, w_is0, w_match, w_want, w_full, w_push, w_eof, w_fire;
  logic [AW-1:0] w_rd_nxt;
  logic [255:0]  w_head_data;
  logic [3:0]    w_head_tag;

  assign w_acc   = in_valid && enable && ({1'b0, in_channel} < LP_NCH);
  assign w_is0   = (in_channel == 8'd0);
  assign w_match = r_synced && !w_is0 && (in_channel == r_expected);
  assign w_want  = w_acc && (w_is0 || w_match);
  assign w_full  = (r_count == LP_DEPTH);
  assign w_push  = w_want && !w_full;
  assign w_eof   = !w_is0 && (in_channel == LP_LAST);
  assign w_fire  = r_out_valid && out_ready;

  assign w_rd_nxt    = r_rd_ptr + AW'(1);
  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_head_tag  = r_mem_tag[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= in_data;
      r_mem_tag[r_wr_ptr]  <= {w_is0, w_eof, r_ovf_pend, r_seq_pend};
    end
  end

  // Decision point shared by IDLE, end of a data entry and end of a trailer.
  // After a pop it looks one entry ahead so back-to-back entries emit without bubbles.
  logic        w_dec, w_dec_avail;
  logic [3:0]  w_dec_tag;
  logic [31:0] w_dec_word;

  always_comb begin
    w_state_n      = r_state;
    w_k_n          = r_k;
    w_out_valid_n  = r_out_valid;
    w_out_data_n   = r_out_data;
    w_frame_cnt_n  = r_frame_cnt;
    w_frame_open_n = r_frame_open;
    w_rx_cnt_n     = r_rx_cnt;
    w_frame_done_n = 1'b0;
    w_pop          = 1'b0;
    w_dec          = 1'b0;
    w_dec_avail    = (r_count != '0);
    w_dec_tag      = w_head_tag;
    w_dec_word     = w_head_data[31:0];
    case (r_state)
      S_IDLE: w_dec = 1'b1;
      S_HDR: if (w_fire) begin
        w_state_n      = S_CNT;
        w_out_data_n   = r_frame_cnt;
        w_frame_cnt_n  = r_frame_cnt + 32'd1;
        w_frame_open_n = 1'b1;
        w_rx_cnt_n     = 8'd0;
      end
      S_CNT: if (w_fire) begin
        w_state_n    = S_DATA;
        w_k_n        = 3'd0;
        w_out_data_n = w_head_data[31:0];
      end
      S_DATA: if (w_fire) begin
        if (r_k != 3'd7) begin
          w_k_n        = r_k + 3'd1;
          w_out_data_n = w_head_data[{w_k_n, 5'b0} +: 32];
        end else begin
          w_pop      = 1'b1;
          w_rx_cnt_n = r_rx_cnt + 8'd1;
          if (w_head_tag[2]) begin
            w_state_n      = S_TRL;
            w_out_data_n   = {8'hEE, w_rx_cnt_n, 14'b0, 2'b00};
            w_frame_open_n = 1'b0;
          end else begin
            w_dec       = 1'b1;
            w_dec_avail = (r_count[AW:1] != '0);
            w_dec_tag   = r_mem_tag[w_rd_nxt];
            w_dec_word  = r_mem_data[w_rd_nxt][31:0];
          end
        end
      end
      S_TRL: if (w_fire) begin
        w_frame_done_n = 1'b1;
        w_dec          = 1'b1;
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_dec) begin
      w_k_n = 3'd0;
      if (!w_dec_avail) begin
        w_state_n     = S_IDLE;
        w_out_valid_n = 1'b0;
      end else if (w_dec_tag[3]) begin
        w_out_valid_n = 1'b1;
        if (r_frame_open) begin
          w_state_n      = S_TRL;
          w_out_data_n   = {8'hEE, w_rx_cnt_n, 14'b0, w_dec_tag[1:0]};
          w_frame_open_n = 1'b0;
        end else begin
          w_state_n    = S_HDR;
          w_out_data_n = MAGIC;
        end
      end else begin
        w_state_n     = S_DATA;
        w_out_valid_n = 1'b1;
        w_out_data_n  = w_dec_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_k          <= 3'd0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 32'd0;
      r_frame_cnt  <= 32'd0;
      r_frame_open <= 1'b0;
      r_rx_cnt     <= 8'd0;
      r_frame_done <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_synced     <= 1'b0;
      r_expected   <= 8'd0;
      r_ovf_pend   <= 1'b0;
      r_seq_pend   <= 1'b0;
      r_enable_d   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_k          <= w_k_n;
      r_out_valid  <= w_out_valid_n;
      r_out_data   <= w_out_data_n;
      r_frame_cnt  <= w_frame_cnt_n;
      r_frame_open <= w_frame_open_n;
      r_rx_cnt     <= w_rx_cnt_n;
      r_frame_done <= w_frame_done_n;
      r_enable_d   <= enable;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_acc) begin
        if (w_want && w_full) begin
          r_synced   <= 1'b0;
          r_ovf_pend <= 1'b1;
          r_overflow <= 1'b1;
        end else if (w_is0) begin
          r_synced   <= 1'b1;
          r_expected <= 8'd1;
          r_ovf_pend <= 1'b0;
          r_seq_pend <= 1'b0;
        end else if (w_match) begin
          r_expected <= r_expected + 8'd1;
          if (w_eof) r_synced <= 1'b0;
        end else if (r_synced) begin
          r_synced   <= 1'b0;
          r_seq_pend <= 1'b1;
        end
      end else if (r_enable_d && !enable && r_synced) begin
        r_synced   <= 1'b0;
        r_seq_pend <= 1'b1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule
